// File: rtl/ascii2bcd.sv
// Serial ASCII-to-BCD line parser: accumulates decimal digits one byte per strobe and
// publishes a right-justified packed BCD word when a CR/LF terminator closes the line.
module ascii2bcd #(
  parameter int CHAR_LEN = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_data,
  input  logic [7:0]              data,
  output logic [4*CHAR_LEN-1:0]   bcd,
  output logic [7:0]              ndigits,
  output logic                    bcd_valid,
  output logic                    err
);

  localparam int BW = 4 * CHAR_LEN;
  localparam int CW = $clog2(CHAR_LEN + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DIGITS  = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [7:0]    ndig_q, ndig_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic          is_digit;
  logic          is_term;
  logic [BW-1:0] nib_ext;

  assign is_digit = (data >= 8'h30) && (data <= 8'h39);
  assign is_term  = (data == 8'h0D) || (data == 8'h0A);
  assign nib_ext  = BW'(data[3:0]);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (new_data) begin
      case (state_q)
        ST_IDLE: begin
          if (is_digit) begin
            acc_d   = nib_ext;
            cnt_d   = CW'(1);
            state_d = ST_DIGITS;
          end else if (!is_term) begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
        ST_DIGITS: begin
          if (is_digit) begin
            if (cnt_q == CW'(CHAR_LEN)) begin
              // Too many digits: the whole line is dropped, not truncated.
              err_d   = 1'b1;
              state_d = ST_DISCARD;
            end else begin
              acc_d = (acc_q << 4) | nib_ext;
              cnt_d = cnt_q + CW'(1);
            end
          end else if (is_term) begin
            bcd_d   = acc_q;
            ndig_d  = 8'(cnt_q);
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (is_term) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ndig_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bcd       = bcd_q;
  assign ndigits   = ndig_q;
  assign bcd_valid = valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ascii2bcd.sv
// Directed bench for ascii2bcd: a per-byte vector table plus hand-written
// reset, gapped-strobe and decimal sweep sequences.
module tb_ascii2bcd;

  logic        clk;
  logic        rst;
  logic        new_data;
  logic [7:0]  data;
  logic [11:0] bcd;
  logic [7:0]  ndigits;
  logic        bcd_valid;
  logic        err;

  int checks;
  int errors;

  ascii2bcd #(.CHAR_LEN(3)) dut (
    .clk(clk), .rst(rst), .new_data(new_data), .data(data),
    .bcd(bcd), .ndigits(ndigits), .bcd_valid(bcd_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        e;
    logic [11:0] b;
    logic [7:0]  n;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] d, input logic v, input logic e,
                     input logic [11:0] b, input logic [7:0] n);
    vec_t r;
    r.d = d; r.v = v; r.e = e; r.b = b; r.n = n;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One strobe; outputs are sampled 1 time unit after the capturing edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    new_data = 1'b1;
    data     = b;
    @(posedge clk);
    #1;
    new_data = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic v, input logic e,
                           input logic [11:0] b, input logic [7:0] n);
    chk({tag, ".valid"}, 32'(bcd_valid), 32'(v));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".bcd"}, 32'(bcd), 32'(b));
    chk({tag, ".ndigits"}, 32'(ndigits), 32'(n));
  endtask

  task automatic idle_cycle(input string tag, input logic [11:0] b, input logic [7:0] n);
    @(negedge clk);
    new_data = 1'b0;
    @(posedge clk);
    #1;
    check_out(tag, 1'b0, 1'b0, b, n);
  endtask

  initial begin
    logic [7:0]  gdat [4];
    logic [11:0] exp_b;
    int          v;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    new_data = 1'b0;
    data     = 8'h00;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 1'b0, 12'h000, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // "007\r"
    add("0", 0, 0, 12'h000, 0); add("0", 0, 0, 12'h000, 0);
    add("7", 0, 0, 12'h000, 0); add(8'h0D, 1, 0, 12'h007, 3);
    // "65\n"
    add("6", 0, 0, 12'h007, 3); add("5", 0, 0, 12'h007, 3);
    add(8'h0A, 1, 0, 12'h065, 2);
    // "9\r\n": single result
    add("9", 0, 0, 12'h065, 2); add(8'h0D, 1, 0, 12'h009, 1);
    add(8'h0A, 0, 0, 12'h009, 1);
    // "1234\r": overflow on '4'
    add("1", 0, 0, 12'h009, 1); add("2", 0, 0, 12'h009, 1);
    add("3", 0, 0, 12'h009, 1); add("4", 0, 1, 12'h009, 1);
    add(8'h0D, 0, 0, 12'h009, 1);
    // "300\r"
    add("3", 0, 0, 12'h009, 1); add("0", 0, 0, 12'h009, 1);
    add("0", 0, 0, 12'h009, 1); add(8'h0D, 1, 0, 12'h300, 3);
    // "9x1\r" then "\r"
    add("9", 0, 0, 12'h300, 3); add("x", 0, 1, 12'h300, 3);
    add("1", 0, 0, 12'h300, 3); add(8'h0D, 0, 0, 12'h300, 3);
    add(8'h0D, 0, 0, 12'h300, 3);
    // Class boundaries: '/' in IDLE, ':' after a digit, then "0\r"
    add("/", 0, 1, 12'h300, 3); add(8'h0A, 0, 0, 12'h300, 3);
    add("1", 0, 0, 12'h300, 3); add(":", 0, 1, 12'h300, 3);
    add("5", 0, 0, 12'h300, 3); add(8'h0A, 0, 0, 12'h300, 3);
    add("0", 0, 0, 12'h300, 3); add(8'h0D, 1, 0, 12'h000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      send(tbl[i].d);
      check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].e, tbl[i].b, tbl[i].n);
      $display("vec %0d: data=0x%02h bcd=0x%03h nd=%0d v=%0b e=%0b",
               i, tbl[i].d, bcd, ndigits, bcd_valid, err);
    end
    idle_cycle("post_tbl", 12'h000, 8'd1);

    // Reset mid-line, with a simultaneous terminator strobe that must lose to rst.
    send("6"); send("5");
    @(negedge clk);
    rst = 1'b1; new_data = 1'b1; data = 8'h0D;
    @(posedge clk);
    #1;
    check_out("rst_mid", 1'b0, 1'b0, 12'h000, 8'd0);
    @(negedge clk);
    rst = 1'b0; new_data = 1'b0;
    send("4");
    check_out("rst_4", 1'b0, 1'b0, 12'h000, 8'd0);
    send(8'h0D);
    check_out("rst_cr", 1'b1, 1'b0, 12'h004, 8'd1);
    $display("reset-mid-line: bcd=0x%03h nd=%0d", bcd, ndigits);
    idle_cycle("rst_pulse_drop", 12'h004, 8'd1);

    // Gapped strobes "909\r".
    gdat[0] = "9"; gdat[1] = "0"; gdat[2] = "9"; gdat[3] = 8'h0D;
    for (int i = 0; i < 4; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) idle_cycle("gap_idle", 12'h004, 8'd1);
      send(gdat[i]);
      if (i < 3) check_out("gap_dig", 1'b0, 1'b0, 12'h004, 8'd1);
    end
    check_out("gap_done", 1'b1, 1'b0, 12'h909, 8'd3);
    $display("gapped: bcd=0x%03h nd=%0d", bcd, ndigits);
    idle_cycle("gap_pulse_drop", 12'h909, 8'd3);

    // Sweep of 30 three-digit values across 000..659.
    for (int i = 0; i < 30; i++) begin
      v = (i * 659) / 29;
      exp_b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      send(8'h30 + 8'(v / 100));
      send(8'h30 + 8'((v / 10) % 10));
      send(8'h30 + 8'(v % 10));
      send((i % 2) ? 8'h0A : 8'h0D);
      check_out($sformatf("sweep%0d", v), 1'b1, 1'b0, exp_b, 8'd3);
      $display("sweep %03d: bcd=0x%03h nd=%0d", v, bcd, ndigits);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
